uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a FIFO with per-frame latched configuration,
// parity, one/two stop bits, break generation and CTS flow control.
module uart_tx_fifo #(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_tick,
    input  logic                          wr_en_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    input  logic [2:0]                    data_bit_num_i,
    input  logic                          parity_en_i,
    input  logic                          parity_type_i,
    input  logic                          stop_bit_num_i,
    input  logic                          break_i,
    input  logic                          cts_n_i,
    input  logic                          clr_ovf_i,
    output logic                          tx_o,
    output logic                          tx_done_o,
    output logic                          busy_o,
    output logic                          fifo_full_o,
    output logic                          fifo_empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level;
    logic              push, pop, launch, can_start;
    logic [DATA_W-1:0] fifo_head, masked, sh, sh_n;
    logic [3:0]        nb_cfg, nb, nb_n, idx, idx_n;
    logic              par_en, par_en_n, par, par_n, stop2, stop2_n;
    logic              stop_cnt, stop_cnt_n, brk, brk_n, tx, tx_n, done, done_n;

    assign fifo_head    = mem[rd_ptr];
    assign fifo_full_o  = level == LW'(FIFO_DEPTH);
    assign fifo_empty_o = level == '0;
    assign fifo_level_o = level;
    assign push         = wr_en_i && (!fifo_full_o || pop);
    assign tx_o         = tx;
    assign tx_done_o    = done;
    assign busy_o       = state != IDLE;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_data_i;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
            if (wr_en_i && !push) overflow_o <= 1'b1;
            else if (clr_ovf_i) overflow_o <= 1'b0;
        end

    // Word is masked to the configured width at launch, so parity and shifting see only active bits.
    always_comb begin
        can_start  = !fifo_empty_o && !cts_n_i && !break_i;
        nb_cfg     = ({1'b0, data_bit_num_i} > 4'(DATA_W - 5)) ? 4'(DATA_W) : 4'd5 + {1'b0, data_bit_num_i};
        masked     = fifo_head & ~({DATA_W{1'b1}} << nb_cfg);
        state_n    = state;
        sh_n       = sh;
        nb_n       = nb;
        idx_n      = idx;
        par_en_n   = par_en;
        par_n      = par;
        stop2_n    = stop2;
        stop_cnt_n = stop_cnt;
        brk_n      = brk;
        tx_n       = tx;
        done_n     = 1'b0;
        launch     = 1'b0;
        pop        = 1'b0;
        if (tx_tick) begin
            case (state)
                IDLE: begin
                    if (break_i) begin
                        state_n = BREAK;
                        tx_n    = 1'b0;
                    end else launch = can_start;
                end
                START: begin
                    state_n = DATA;
                    tx_n    = sh[0];
                    sh_n    = sh >> 1;
                    idx_n   = '0;
                end
                DATA: begin
                    if (idx == nb - 4'd1) begin
                        state_n    = par_en ? PARITY : STOP;
                        tx_n       = par_en ? par : 1'b1;
                        stop_cnt_n = 1'b0;
                    end else begin
                        idx_n = idx + 4'd1;
                        tx_n  = sh[0];
                        sh_n  = sh >> 1;
                    end
                end
                PARITY: begin
                    state_n    = STOP;
                    tx_n       = 1'b1;
                    stop_cnt_n = 1'b0;
                end
                STOP: begin
                    if (stop2 && !stop_cnt) stop_cnt_n = 1'b1;
                    else begin
                        done_n  = !brk;
                        state_n = IDLE;
                        tx_n    = 1'b1;
                        launch  = can_start;
                    end
                end
                BREAK: begin
                    if (!break_i) begin
                        state_n    = STOP;
                        tx_n       = 1'b1;
                        stop2_n    = stop_bit_num_i;
                        stop_cnt_n = 1'b0;
                        brk_n      = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        if (launch) begin
            pop      = 1'b1;
            state_n  = START;
            tx_n     = 1'b0;
            sh_n     = masked;
            nb_n     = nb_cfg;
            par_en_n = parity_en_i;
            par_n    = (^masked) ^ parity_type_i;
            stop2_n  = stop_bit_num_i;
            brk_n    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            sh       <= '0;
            nb       <= 4'd5;
            idx      <= '0;
            par_en   <= 1'b0;
            par      <= 1'b0;
            stop2    <= 1'b0;
            stop_cnt <= 1'b0;
            brk      <= 1'b0;
            tx       <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            sh       <= sh_n;
            nb       <= nb_n;
            idx      <= idx_n;
            par_en   <= par_en_n;
            par      <= par_n;
            stop2    <= stop2_n;
            stop_cnt <= stop_cnt_n;
            brk      <= brk_n;
            tx       <= tx_n;
            done     <= done_n;
        end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed vector table plus hand sequences for backpressure, break and reset.
module tb_uart_tx_fifo;
    logic       clk = 0, rst = 1, tx_tick = 0, wr_en_i = 0;
    logic [8:0] wr_data_i = '0;
    logic [2:0] data_bit_num_i = 3'd3;
    logic       parity_en_i = 0, parity_type_i = 0, stop_bit_num_i = 0;
    logic       break_i = 0, cts_n_i = 1, clr_ovf_i = 0;
    logic       tx_o, tx_done_o, busy_o, fifo_full_o, fifo_empty_o, overflow_o;
    logic [4:0] fifo_level_o;

    uart_tx_fifo dut (
        .clk(clk), .rst(rst), .tx_tick(tx_tick), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
        .data_bit_num_i(data_bit_num_i), .parity_en_i(parity_en_i), .parity_type_i(parity_type_i),
        .stop_bit_num_i(stop_bit_num_i), .break_i(break_i), .cts_n_i(cts_n_i), .clr_ovf_i(clr_ovf_i),
        .tx_o(tx_o), .tx_done_o(tx_done_o), .busy_o(busy_o), .fifo_full_o(fifo_full_o),
        .fifo_empty_o(fifo_empty_o), .fifo_level_o(fifo_level_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    int done_cnt = 0;
    always @(posedge clk) if (tx_done_o) done_cnt <= done_cnt + 1;

    typedef struct {
        logic [8:0]  data;
        logic [2:0]  dbn;
        logic        pen, ptype, stop2;
        int          len;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [8];
    int          passed = 0, total = 0, base, bad;
    logic        stable, b, e;
    logic [31:0] got;

    task automatic chk(input string name, input logic [31:0] g, input logic [31:0] x);
        total++;
        if (g !== x) $display("FAIL %s: got %0h expected %0h", name, g, x);
        else passed++;
    endtask

    task automatic tick(output logic v);
        @(negedge clk); tx_tick = 1;
        @(negedge clk); tx_tick = 0; v = tx_o;
        @(negedge clk); if (tx_o !== v) stable = 0;
    endtask

    task automatic wr(input logic [8:0] d);
        @(negedge clk); wr_en_i = 1; wr_data_i = d;
        @(negedge clk); wr_en_i = 0;
    endtask

    initial begin
        vecs[0] = '{9'h0A5, 3'd3, 1'b0, 1'b0, 1'b0, 10, 32'b0101001011};
        vecs[1] = '{9'h07F, 3'd2, 1'b1, 1'b0, 1'b1, 11, 32'b01111111111};
        vecs[2] = '{9'h03C, 3'd1, 1'b1, 1'b1, 1'b0, 9,  32'b000111111};
        vecs[3] = '{9'h1FF, 3'd4, 1'b0, 1'b0, 1'b0, 11, 32'b01111111111};
        vecs[4] = '{9'h155, 3'd2, 1'b0, 1'b0, 1'b0, 9,  32'b010101011};
        vecs[5] = '{9'h100, 3'd7, 1'b0, 1'b0, 1'b0, 11, 32'b00000000011};
        vecs[6] = '{9'h0A5, 3'd3, 1'b1, 1'b0, 1'b0, 11, 32'b01010010101};
        vecs[7] = '{9'h1F3, 3'd0, 1'b1, 1'b1, 1'b1, 9,  32'b011001011};
        repeat (3) @(negedge clk);
        chk("reset_state", {tx_o, tx_done_o, busy_o, fifo_empty_o, fifo_full_o, overflow_o}, 6'b100100);
        chk("reset_level", fifo_level_o, 0);
        rst = 0;
        @(negedge clk);
        chk("idle_state", {tx_o, busy_o, fifo_empty_o}, 3'b101);

        for (int k = 0; k < 8; k++) begin
            data_bit_num_i = vecs[k].dbn; parity_en_i = vecs[k].pen;
            parity_type_i = vecs[k].ptype; stop_bit_num_i = vecs[k].stop2; cts_n_i = 1;
            wr(vecs[k].data);
            chk($sformatf("level_wr%0d", k), fifo_level_o, 1);
            base = done_cnt; got = 0; stable = 1; cts_n_i = 0;
            for (int i = 0; i < vecs[k].len; i++) begin
                tick(b);
                got = {got[30:0], b};
                if (i == 0) begin
                    data_bit_num_i = ~vecs[k].dbn; parity_en_i = ~vecs[k].pen;
                    parity_type_i = ~vecs[k].ptype; stop_bit_num_i = ~vecs[k].stop2; cts_n_i = 1;
                end
            end
            tick(b);
            chk($sformatf("frame%0d", k), got, vecs[k].exp);
            chk($sformatf("stable%0d", k), stable, 1);
            chk($sformatf("done%0d", k), done_cnt - base, 1);
            chk($sformatf("idle%0d", k), {busy_o, fifo_empty_o, tx_o, fifo_level_o}, {3'b011, 5'd0});
        end

        data_bit_num_i = 3'd3; parity_en_i = 0; parity_type_i = 0; stop_bit_num_i = 0; cts_n_i = 1;
        for (int i = 0; i < 17; i++) wr(9'(i));
        chk("full_flags", {fifo_full_o, fifo_empty_o, overflow_o}, 3'b101);
        chk("full_level", fifo_level_o, 16);
        @(negedge clk); wr_en_i = 1; clr_ovf_i = 1; wr_data_i = 9'h1AA;
        @(negedge clk); wr_en_i = 0; clr_ovf_i = 0;
        chk("ovf_drop_wins", {overflow_o, fifo_level_o}, {1'b1, 5'd16});
        @(negedge clk); clr_ovf_i = 1;
        @(negedge clk); clr_ovf_i = 0;
        chk("ovf_clear", overflow_o, 0);
        base = done_cnt; bad = 0; cts_n_i = 0;
        @(negedge clk); tx_tick = 1; wr_en_i = 1; wr_data_i = 9'd16;
        @(negedge clk); tx_tick = 0; wr_en_i = 0; b = tx_o;
        chk("full_push_pop", {fifo_full_o, overflow_o, fifo_level_o}, {2'b10, 5'd16});
        for (int n = 0; n < 170; n++) begin
            if (n > 0) tick(b);
            e = (n % 10 == 0) ? 1'b0 : (n % 10 == 9) ? 1'b1 : ((n / 10) >> ((n % 10) - 1)) % 2 == 1;
            if (b !== e) bad++;
        end
        tick(b);
        chk("b2b_stream_errs", bad, 0);
        chk("b2b_done", done_cnt - base, 17);
        chk("b2b_idle", {busy_o, fifo_empty_o, tx_o}, 3'b011);

        cts_n_i = 1;
        wr(9'h0A5);
        base = done_cnt; got = 0; cts_n_i = 0;
        for (int i = 0; i < 17; i++) begin
            tick(b);
            got = {got[30:0], b};
            if (i == 2) break_i = 1;
            if (i == 13) begin
                chk("in_break", {busy_o, tx_o}, 2'b10);
                break_i = 0; stop_bit_num_i = 1;
            end
            if (i == 15) chk("break_stop2_busy", busy_o, 1);
        end
        chk("break_stream", got, 32'b01010010111000111);
        chk("break_done", done_cnt - base, 1);
        chk("break_idle", {busy_o, tx_o}, 2'b01);

        stop_bit_num_i = 0; cts_n_i = 1;
        wr(9'h000); wr(9'h000);
        cts_n_i = 0;
        tick(b); tick(b);
        chk("pre_rst", {busy_o, tx_o, fifo_level_o}, {2'b10, 5'd1});
        #2 rst = 1;
        #1 chk("rst_async", {tx_o, tx_done_o, busy_o, fifo_empty_o, fifo_full_o, overflow_o}, 6'b100100);
        chk("rst_level", fifo_level_o, 0);
        @(negedge clk); rst = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
